// File: rtl/exp_golomb_decoder.sv
// Streaming order-0 Exp-Golomb decoder: consumes bits from an upstream window
// and presents each decoded unsigned value with a valid/ready handshake.
module exp_golomb_decoder #(
  parameter int WIDTH_OUT      = 8,
  parameter int LOG2_WIDTH_OUT = 3,
  parameter int VALUE_WIDTH    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH_OUT-1:0]      window,
  input  logic                      window_ready,
  output logic [LOG2_WIDTH_OUT:0]   pop,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [VALUE_WIDTH-1:0]    out_data,
  output logic                      error
);

  localparam int MAX_PREFIX = VALUE_WIDTH - 1;
  localparam int ZC_MAX     = MAX_PREFIX + WIDTH_OUT;
  localparam int ZC_W       = $clog2(ZC_MAX + 1);
  localparam int N_W        = ZC_W + 1;
  localparam int REM_W      = $clog2(VALUE_WIDTH) + 1;
  localparam int P_W        = LOG2_WIDTH_OUT + 1;

  typedef enum logic [1:0] {
    S_PREFIX,
    S_SUFFIX,
    S_OUTPUT,
    S_ERROR
  } state_t;

  state_t                 state, state_next;
  logic [ZC_W-1:0]        zero_cnt, zero_cnt_next;
  logic [REM_W-1:0]       remaining, remaining_next;
  logic [VALUE_WIDTH-1:0] acc, acc_next;
  logic [VALUE_WIDTH-1:0] out_data_next;

  logic [P_W-1:0]         lead_zeros;
  logic                   all_zero;
  logic [N_W-1:0]         prefix_len;
  logic [N_W-1:0]         zc_sum;
  logic [P_W-1:0]         suffix_k;
  logic [VALUE_WIDTH-1:0] suffix_bits;
  logic [VALUE_WIDTH-1:0] acc_shifted;
  logic [REM_W-1:0]       remaining_after;

  // Ascending scan: the last set bit found is the most significant one.
  always_comb begin
    all_zero   = (window == '0);
    lead_zeros = P_W'(WIDTH_OUT);
    for (int unsigned i = 0; i < WIDTH_OUT; i++) begin
      if (window[i]) lead_zeros = P_W'(WIDTH_OUT - 1 - i);
    end
  end

  always_comb begin
    state_next      = state;
    zero_cnt_next   = zero_cnt;
    remaining_next  = remaining;
    acc_next        = acc;
    out_data_next   = out_data;
    pop             = '0;

    prefix_len      = N_W'(zero_cnt) + N_W'(lead_zeros);
    zc_sum          = N_W'(zero_cnt) + N_W'(WIDTH_OUT);
    suffix_k        = (remaining < REM_W'(WIDTH_OUT)) ? P_W'(remaining) : P_W'(WIDTH_OUT);
    // Top-k window bits, right-aligned; equivalent to window[WIDTH_OUT-1 -: k].
    suffix_bits     = VALUE_WIDTH'(window >> (WIDTH_OUT - int'(suffix_k)));
    acc_shifted     = acc << suffix_k;
    remaining_after = remaining - REM_W'(suffix_k);

    unique case (state)
      S_PREFIX: begin
        if (window_ready) begin
          if (all_zero) begin
            pop = P_W'(WIDTH_OUT);
            zero_cnt_next = (zc_sum > N_W'(ZC_MAX)) ? ZC_W'(ZC_MAX) : ZC_W'(zc_sum);
            if (zc_sum > N_W'(MAX_PREFIX)) state_next = S_ERROR;
          end else begin
            pop           = lead_zeros + P_W'(1);
            zero_cnt_next = '0;
            if (prefix_len > N_W'(MAX_PREFIX)) begin
              state_next = S_ERROR;
            end else if (prefix_len == '0) begin
              acc_next      = VALUE_WIDTH'(1);
              out_data_next = '0;
              state_next    = S_OUTPUT;
            end else begin
              acc_next       = VALUE_WIDTH'(1);
              remaining_next = REM_W'(prefix_len);
              state_next     = S_SUFFIX;
            end
          end
        end
      end
      S_SUFFIX: begin
        if (window_ready) begin
          pop            = suffix_k;
          acc_next       = acc_shifted | suffix_bits;
          remaining_next = remaining_after;
          if (remaining_after == '0) begin
            out_data_next = acc_next - VALUE_WIDTH'(1);
            state_next    = S_OUTPUT;
          end
        end
      end
      S_OUTPUT: begin
        if (out_ready) state_next = S_PREFIX;
      end
      S_ERROR: begin
      end
      default: state_next = S_PREFIX;
    endcase

    if (!rst) pop = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_PREFIX;
      zero_cnt  <= '0;
      remaining <= '0;
      acc       <= '0;
      out_data  <= '0;
    end else begin
      state     <= state_next;
      zero_cnt  <= zero_cnt_next;
      remaining <= remaining_next;
      acc       <= acc_next;
      out_data  <= out_data_next;
    end
  end

  assign out_valid = (state == S_OUTPUT);
  assign error     = (state == S_ERROR);

endmodule

// File: tb/tb_exp_golomb_decoder.sv
// Directed bench for exp_golomb_decoder: hand-computed pops and decoded values.
module tb_exp_golomb_decoder;

  logic        clk;
  logic        rst;
  logic [7:0]  window;
  logic        window_ready;
  logic [3:0]  pop;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        error;

  int tests_run = 0;
  int tests_failed = 0;

  exp_golomb_decoder #(
    .WIDTH_OUT      (8),
    .LOG2_WIDTH_OUT (3),
    .VALUE_WIDTH    (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .window       (window),
    .window_ready (window_ready),
    .pop          (pop),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .error        (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one window, check the combinational pop, then clock it in.
  task automatic feed(input string tag, input logic [7:0] w, input int exp_pop);
    window       = w;
    window_ready = 1'b1;
    #2;
    check(tag, 32'(pop), 32'(exp_pop));
    tick();
  endtask

  task automatic expect_output(input string tag, input logic [31:0] exp_val);
    window_ready = 1'b0;
    #2;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"}, out_data, exp_val);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_released"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst          = 1'b0;
    window       = 8'h80;
    window_ready = 1'b1;
    out_ready    = 1'b0;
    #2;
    check("rst_pop", 32'(pop), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_data", out_data, 32'd0);
    tick();
    tick();
    rst = 1'b1;

    // Single-bit code "1" -> 0
    feed("one_bit_pop", 8'b1010_1010, 1);
    expect_output("one_bit", 32'd0);

    // "00101" -> 4, then hold off the consumer for 5 cycles
    feed("c00101_prefix", 8'b0010_1000, 3);
    feed("c00101_suffix", 8'b0100_0000, 2);
    window       = 8'hFF;
    window_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #2;
      check("hold_pop", 32'(pop), 32'd0);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", out_data, 32'd4);
      tick();
    end
    out_ready = 1'b1;
    #2;
    check("accept_valid", 32'(out_valid), 32'd1);
    tick();
    window_ready = 1'b0;
    out_ready    = 1'b0;
    check("accept_released", 32'(out_valid), 32'd0);

    // N=10, all-ones suffix -> 2046, with a 3-cycle window stall mid-suffix
    feed("n10_zeros", 8'b0000_0000, 8);
    feed("n10_prefix", 8'b0011_1111, 3);
    feed("n10_suffix_a", 8'b1111_1111, 8);
    window_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      check("stall_pop", 32'(pop), 32'd0);
      check("stall_valid", 32'(out_valid), 32'd0);
      tick();
    end
    feed("n10_suffix_b", 8'b1100_0000, 2);
    expect_output("n10", 32'd2046);

    // "011" -> 2
    feed("c011_prefix", 8'b0110_0000, 2);
    feed("c011_suffix", 8'b1000_0000, 1);
    expect_output("c011", 32'd2);

    // Longest legal prefix N=31 with all-ones suffix -> 0xFFFFFFFE
    feed("max_z0", 8'h00, 8);
    feed("max_z1", 8'h00, 8);
    feed("max_z2", 8'h00, 8);
    feed("max_prefix", 8'h01, 8);
    feed("max_s0", 8'hFF, 8);
    feed("max_s1", 8'hFF, 8);
    feed("max_s2", 8'hFF, 8);
    feed("max_s3", 8'hFF, 7);
    check("max_no_error", 32'(error), 32'd0);
    expect_output("max", 32'hFFFF_FFFE);

    // Reset mid-suffix discards the partial "00101" code
    feed("midrst_prefix", 8'b0010_1000, 3);
    window       = 8'b0100_0000;
    window_ready = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check("midrst_pop", 32'(pop), 32'd0);
    tick();
    rst = 1'b1;
    feed("midrst_restart", 8'b1000_0000, 1);
    expect_output("midrst", 32'd0);

    // 32 zeros overflow the prefix -> sticky error until reset
    feed("err_z0", 8'h00, 8);
    feed("err_z1", 8'h00, 8);
    feed("err_z2", 8'h00, 8);
    check("err_not_yet", 32'(error), 32'd0);
    feed("err_z3", 8'h00, 8);
    window = 8'h80;
    #2;
    check("err_flag", 32'(error), 32'd1);
    check("err_pop", 32'(pop), 32'd0);
    check("err_valid", 32'(out_valid), 32'd0);
    tick();
    tick();
    check("err_sticky", 32'(error), 32'd1);
    rst = 1'b0;
    #1;
    check("err_clr_error", 32'(error), 32'd0);
    check("err_clr_valid", 32'(out_valid), 32'd0);
    check("err_clr_pop", 32'(pop), 32'd0);
    tick();
    rst = 1'b1;
    feed("post_err_pop", 8'b1000_0000, 1);
    expect_output("post_err", 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no end expected end");
    $fatal(1, "timeout");
  end

endmodule
